// File: rtl/ref_pkg.sv
// ref_pkg: refresh thresholds shared by the refresh timer and by the RAM/FSB
// refresh arbitration, so every block agrees on the same interval and urgency limits.
package ref_pkg;

    localparam int unsigned DEF_REF_PERIOD  = 375;  // CLK_FSB cycles per refresh tick
    localparam int unsigned DEF_URGENT_AGE  = 128;  // unserviced RefReq cycles before urgent
    localparam int unsigned DEF_URGENT_PEND = 2;    // owed count that forces urgent
    localparam int unsigned DEF_MAX_PEND    = 7;    // owed-count saturation value
    localparam int unsigned DEF_INIT_REFS   = 8;    // power-up refresh burst

    localparam int unsigned PEND_W = 3;

    // Power-up burst can never exceed what the owed counter is able to hold.
    function automatic int unsigned clip_init(input int unsigned init, input int unsigned lim);
        return (init > lim) ? lim : init;
    endfunction

endpackage

// File: rtl/ref_div.sv
// ref_div: reloadable down-counter that produces the refresh interval tick.
//   clk_i   - clock
//   rst_ni  - asynchronous active-low reset; counter loads Period-1
//   en_i    - 1 = count down, 0 = hold
//   tick_o  - one-cycle pulse in the enabled cycle where the counter is at zero
module ref_div #(
    parameter int unsigned Period = 375
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic en_i,
    output logic tick_o
);

    localparam int unsigned DivW = (Period > 1) ? $clog2(Period) : 1;
    localparam logic [DivW-1:0] Reload = DivW'(Period - 1);

    logic [DivW-1:0] div_q, div_d;

    always_comb begin
        div_d  = div_q;
        tick_o = 1'b0;
        if (en_i) begin
            if (div_q == '0) begin
                div_d  = Reload;
                tick_o = 1'b1;
            end else begin
                div_d = div_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            div_q <= Reload;
        end else begin
            div_q <= div_d;
        end
    end

endmodule

// File: rtl/ref_timer.sv
// ref_timer: DRAM refresh timer. Counts refresh intervals, keeps a saturating count
// of owed refreshes, escalates to urgent on backlog or on a stale request, and owes
// the power-up refresh burst after every reset.
//   CLK_FSB   - FSB clock
//   nRES      - asynchronous active-low reset
//   RefAck    - one-cycle pulse: RAM committed one refresh
//   RefEn     - 1 = interval counter runs; owed refreshes are requested regardless
//   RefReq    - registered; owed count is non-zero
//   RefUrgent - registered; FSB must stall new accesses and grant refresh
//   RefLost   - registered, sticky until reset; a tick arrived with the counter full
//   Pend      - registered owed-refresh count
module ref_timer
    import ref_pkg::*;
#(
    parameter int unsigned REF_PERIOD  = DEF_REF_PERIOD,
    parameter int unsigned URGENT_AGE  = DEF_URGENT_AGE,
    parameter int unsigned URGENT_PEND = DEF_URGENT_PEND,
    parameter int unsigned MAX_PEND    = DEF_MAX_PEND,
    parameter int unsigned INIT_REFS   = DEF_INIT_REFS
) (
    input  logic              CLK_FSB,
    input  logic              nRES,
    input  logic              RefAck,
    input  logic              RefEn,
    output logic              RefReq,
    output logic              RefUrgent,
    output logic              RefLost,
    output logic [PEND_W-1:0] Pend
);

    localparam int unsigned AgeW = $clog2(URGENT_AGE + 1);
    localparam logic [AgeW-1:0]   AgeMax   = AgeW'(URGENT_AGE);
    localparam logic [PEND_W-1:0] MaxPend  = PEND_W'(MAX_PEND);
    localparam logic [PEND_W-1:0] InitPend = PEND_W'(clip_init(INIT_REFS, MAX_PEND));

    if (MAX_PEND == 0 || MAX_PEND > (2 ** PEND_W) - 1) begin : g_bad_max_pend
        $error("ref_timer: MAX_PEND must be in 1..%0d", (2 ** PEND_W) - 1);
    end
    if (URGENT_AGE == 0) begin : g_bad_urgent_age
        $error("ref_timer: URGENT_AGE must be at least 1");
    end

    logic              tick;
    logic [PEND_W-1:0] pend_q, pend_d;
    logic [AgeW-1:0]   age_q, age_d;
    logic              req_q, req_d;
    logic              urg_q, urg_d;
    logic              lost_q, lost_d;

    ref_div #(
        .Period (REF_PERIOD)
    ) u_div (
        .clk_i  (CLK_FSB),
        .rst_ni (nRES),
        .en_i   (RefEn),
        .tick_o (tick)
    );

    always_comb begin
        pend_d = pend_q;
        lost_d = lost_q;
        age_d  = age_q;

        // A tick and an ack in the same cycle cancel, even with the counter full.
        if (tick && !RefAck) begin
            if (pend_q == MaxPend) begin
                lost_d = 1'b1;
            end else begin
                pend_d = pend_q + 1'b1;
            end
        end else if (!tick && RefAck && pend_q != '0) begin
            pend_d = pend_q - 1'b1;
        end

        // Age tracks how long the current request has gone unserviced.
        if (RefAck || pend_q == '0) begin
            age_d = '0;
        end else if (age_q != AgeMax) begin
            age_d = age_q + 1'b1;
        end

        // Outputs are decoded from next state so they register alongside it.
        req_d = (pend_d != '0);
        urg_d = (32'(pend_d) >= URGENT_PEND) || (age_d == AgeMax);
    end

    always_ff @(posedge CLK_FSB or negedge nRES) begin
        if (!nRES) begin
            pend_q <= InitPend;
            age_q  <= '0;
            req_q  <= 1'b0;
            urg_q  <= 1'b0;
            lost_q <= 1'b0;
        end else begin
            pend_q <= pend_d;
            age_q  <= age_d;
            req_q  <= req_d;
            urg_q  <= urg_d;
            lost_q <= lost_d;
        end
    end

    assign RefReq    = req_q;
    assign RefUrgent = urg_q;
    assign RefLost   = lost_q;
    assign Pend      = pend_q;

endmodule

// File: tb/tb_ref_timer.sv
// tb_ref_timer: three ref_timer instances (defaults; period 10 / age 16 / no burst;
// period 4 / no burst) driven from one directed sequence. Every cycle a behavioural
// model pushes the expected outputs to a scoreboard that is popped after the edge;
// directed checks pin latencies and boundary values.
module tb_ref_timer;

    typedef struct packed {
        logic       req;
        logic       urg;
        logic       lost;
        logic [2:0] pend;
    } obs_t;

    int unsigned per_c  [3] = '{375, 10, 4};
    int unsigned age_c  [3] = '{128, 16, 128};
    int unsigned init_c [3] = '{8, 0, 0};

    logic       clk   = 1'b0;
    logic       n_res = 1'b1;
    logic       en   [3];
    logic       ack  [3];
    logic       req  [3];
    logic       urg  [3];
    logic       lost [3];
    logic [2:0] pend [3];

    int unsigned m_div  [3];
    int unsigned m_age  [3];
    int unsigned m_pend [3];
    bit          m_lost [3];

    obs_t sb_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc      = 0;

    always #5 clk = ~clk;

    ref_timer u_a (
        .CLK_FSB   (clk),
        .nRES      (n_res),
        .RefAck    (ack[0]),
        .RefEn     (en[0]),
        .RefReq    (req[0]),
        .RefUrgent (urg[0]),
        .RefLost   (lost[0]),
        .Pend      (pend[0])
    );

    ref_timer #(
        .REF_PERIOD (10),
        .URGENT_AGE (16),
        .INIT_REFS  (0)
    ) u_b (
        .CLK_FSB   (clk),
        .nRES      (n_res),
        .RefAck    (ack[1]),
        .RefEn     (en[1]),
        .RefReq    (req[1]),
        .RefUrgent (urg[1]),
        .RefLost   (lost[1]),
        .Pend      (pend[1])
    );

    ref_timer #(
        .REF_PERIOD (4),
        .INIT_REFS  (0)
    ) u_c (
        .CLK_FSB   (clk),
        .nRES      (n_res),
        .RefAck    (ack[2]),
        .RefEn     (en[2]),
        .RefReq    (req[2]),
        .RefUrgent (urg[2]),
        .RefLost   (lost[2]),
        .Pend      (pend[2])
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_errors++;
            $error("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_reset_all();
        for (int k = 0; k < 3; k++) begin
            m_div[k]  = per_c[k] - 1;
            m_pend[k] = (init_c[k] > 7) ? 7 : init_c[k];
            m_age[k]  = 0;
            m_lost[k] = 1'b0;
        end
    endtask

    task automatic model_step(input int k);
        bit tick;
        tick = en[k] && (m_div[k] == 0);
        if (en[k]) m_div[k] = (m_div[k] == 0) ? per_c[k] - 1 : m_div[k] - 1;
        if (ack[k] || m_pend[k] == 0) m_age[k] = 0;
        else if (m_age[k] < age_c[k]) m_age[k] = m_age[k] + 1;
        if (tick && !ack[k]) begin
            if (m_pend[k] == 7) m_lost[k] = 1'b1;
            else m_pend[k] = m_pend[k] + 1;
        end else if (!tick && ack[k] && m_pend[k] != 0) begin
            m_pend[k] = m_pend[k] - 1;
        end
    endtask

    // One clock: predict, push, advance, pop and compare; acks are one-cycle pulses.
    task automatic step();
        obs_t e;
        obs_t g;
        for (int k = 0; k < 3; k++) begin
            model_step(k);
            e.req  = (m_pend[k] != 0);
            e.urg  = (m_pend[k] >= 2) || (m_age[k] == age_c[k]);
            e.lost = m_lost[k];
            e.pend = 3'(m_pend[k]);
            sb_q.push_back(e);
        end
        @(posedge clk);
        #1;
        cyc++;
        for (int k = 0; k < 3; k++) begin
            e = sb_q.pop_front();
            g = '{req: req[k], urg: urg[k], lost: lost[k], pend: pend[k]};
            n_checks++;
            assert (g === e) else begin
                n_errors++;
                $error("FAIL sb_dut%0d cyc %0d: got req=%b urg=%b lost=%b pend=%0d, expected req=%b urg=%b lost=%b pend=%0d",
                       k, cyc, g.req, g.urg, g.lost, g.pend, e.req, e.urg, e.lost, e.pend);
            end
        end
        for (int k = 0; k < 3; k++) ack[k] = 1'b0;
    endtask

    initial begin
        int n;
        for (int k = 0; k < 3; k++) begin
            en[k]  = 1'b0;
            ack[k] = 1'b0;
        end

        // Reset held across an edge.
        #1 n_res = 1'b0;
        model_reset_all();
        @(posedge clk);
        #1;
        chk("a_rst_req", req[0], 0);
        chk("a_rst_urg", urg[0], 0);
        chk("a_rst_lost", lost[0], 0);
        chk("a_rst_pend", pend[0], 7);
        chk("b_rst_pend", pend[1], 0);
        chk("c_rst_req", req[2], 0);

        // Release: burst is owed and urgent from the first edge.
        n_res = 1'b1;
        step();
        chk("a_first_req", req[0], 1);
        chk("a_first_urg", urg[0], 1);
        chk("a_first_pend", pend[0], 7);
        chk("b_first_req", req[1], 0);

        // Bring u_a to Pend=2, div=5, then reset it asynchronously.
        for (int i = 0; i < 5; i++) begin
            ack[0] = 1'b1;
            step();
        end
        chk("a_pend_after_5_acks", pend[0], 2);
        en[0] = 1'b1;
        repeat (369) step();
        chk("a_pend_before_rst", pend[0], 2);
        chk("a_urg_before_rst", urg[0], 1);
        #3 n_res = 1'b0;
        model_reset_all();
        #1;
        chk("a_async_req", req[0], 0);
        chk("a_async_urg", urg[0], 0);
        chk("a_async_lost", lost[0], 0);
        chk("a_async_pend", pend[0], 7);
        @(posedge clk);
        #1;
        en[0] = 1'b0;
        n_res = 1'b1;
        step();
        chk("a_rel_pend", pend[0], 7);
        chk("a_rel_req", req[0], 1);

        // Drain the burst with seven acks.
        for (int i = 0; i < 7; i++) begin
            if (i == 6) chk("a_req_before_last_ack", req[0], 1);
            ack[0] = 1'b1;
            step();
            if (i == 6) begin
                chk("a_drain_pend", pend[0], 0);
                chk("a_drain_req", req[0], 0);
            end
            step();
        end
        ack[0] = 1'b1;
        step();
        chk("a_ack_at_zero", pend[0], 0);

        // Divider restarted from REF_PERIOD-1 after the async reset.
        en[0] = 1'b1;
        n = 0;
        do begin
            step();
            n++;
        end while (req[0] !== 1'b1 && n < 400);
        chk("a_first_tick_cycles", n, 375);
        en[0] = 1'b0;

        // u_b: ticks every 10 cycles, ack 3 cycles later, never urgent.
        en[1] = 1'b1;
        n = 0;
        do begin
            step();
            n++;
        end while (req[1] !== 1'b1 && n < 30);
        chk("b_tick1_cycles", n, 10);
        chk("b_tick1_pend", pend[1], 1);
        step();
        step();
        ack[1] = 1'b1;
        step();
        chk("b_ack1_pend", pend[1], 0);
        chk("b_ack1_req", req[1], 0);
        chk("b_ack1_urg", urg[1], 0);
        n = 0;
        do begin
            step();
            n++;
        end while (req[1] !== 1'b1 && n < 30);
        chk("b_tick2_cycles", n, 7);

        // u_b: stale request escalates after exactly URGENT_AGE cycles.
        en[1] = 1'b0;
        n = 0;
        do begin
            step();
            n++;
        end while (urg[1] !== 1'b1 && n < 40);
        chk("b_age_urgent_cycles", n, 16);
        chk("b_age_req", req[1], 1);
        ack[1] = 1'b1;
        step();
        chk("b_age_ack_req", req[1], 0);
        chk("b_age_ack_urg", urg[1], 0);
        chk("b_age_ack_pend", pend[1], 0);

        // u_c: period 4, no ack for 40 cycles.
        en[2] = 1'b1;
        repeat (28) step();
        chk("c_7ticks_pend", pend[2], 7);
        chk("c_7ticks_lost", lost[2], 0);
        repeat (4) step();
        chk("c_8ticks_lost", lost[2], 1);
        chk("c_8ticks_pend", pend[2], 7);
        repeat (8) step();
        chk("c_40cyc_lost", lost[2], 1);
        repeat (3) step();
        ack[2] = 1'b1;
        step();
        chk("c_tick_ack_full_pend", pend[2], 7);
        chk("c_tick_ack_full_lost", lost[2], 1);

        // u_c: tick and ack together at Pend=3.
        en[2] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            ack[2] = 1'b1;
            step();
        end
        chk("c_pend3", pend[2], 3);
        en[2] = 1'b1;
        repeat (3) step();
        ack[2] = 1'b1;
        step();
        chk("c_tick_ack_pend3", pend[2], 3);

        // u_c: ack at Pend=0 does not wrap.
        en[2] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            ack[2] = 1'b1;
            step();
        end
        ack[2] = 1'b1;
        step();
        chk("c_ack_at_zero_pend", pend[2], 0);
        chk("c_ack_at_zero_req", req[2], 0);
        chk("c_lost_sticky", lost[2], 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
